visit_counter_6bit: RTL and testbench

//  Debounces the raw IR break-beam sensor at the birdhouse entrance and counts bird visits.

---
 rtl/visit_counter_6bit_pkg.sv | 17 +
 rtl/visit_counter_6bit_sync_2ff.sv | 23 ++
 rtl/visit_counter_6bit.sv | 112 +++++++++++
 tb/tb_visit_counter_6bit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/visit_counter_6bit_pkg.sv
// Shared constants for the birdhouse visit counter: FSM encodings, counter and timer widths.
// Encodings are fixed because firmware decodes the state from a debug tap.
package visit_counter_6bit_pkg;

    localparam int VISIT_W = 6;
    localparam int TIMER_W = 8;

    localparam logic [VISIT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        OCCUPIED = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

endpackage

// File: rtl/visit_counter_6bit_sync_2ff.sv
// Purpose: two-flop synchronizer for an asynchronous sensor level.
// Latency: 2 cycles from input to output.
// Backpressure: none; a plain level path.
module sync_2ff (
    output logic out,
    input  logic in,
    input  logic clk,
    input  logic reset
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            out    <= 1'b0;
        end else begin
            r_meta <= in;
            out    <= r_meta;
        end
    end

endmodule

// File: rtl/visit_counter_6bit.sv
// Purpose: debounce the entrance break-beam and count bird visits, saturating at 63.
// Latency: count_wE rises DEBOUNCE_CYCLES+2 edges after beam_in is first sampled high.
// Backpressure: none; the downstream count register always accepts count_wE.
module visit_counter_6bit
    import visit_counter_6bit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               beam_in,
    input  logic               clr,
    output logic [VISIT_W-1:0] count_out,
    output logic               count_wE,
    output logic               sat
);

    localparam logic [TIMER_W-1:0] DEB_LAST  = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLDOFF_CYCLES - 1);

    logic               w_beam_s;
    logic               w_count_evt;
    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [VISIT_W-1:0] r_count;
    logic               r_wE;
    logic               r_sat;

    sync_2ff u_sync (
        .out   (w_beam_s),
        .in    (beam_in),
        .clk   (clk),
        .reset (reset)
    );

    assign w_count_evt = (r_state == CONFIRM) && w_beam_s && (r_timer == DEB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_beam_s) begin
                        r_state <= CONFIRM;
                        r_timer <= TIMER_W'(1);
                    end
                end
                CONFIRM: begin
                    if (!w_beam_s) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                    end else if (r_timer == DEB_LAST) begin
                        r_state <= OCCUPIED;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                OCCUPIED: begin
                    // Any re-break restarts the clear-beam debounce window.
                    if (w_beam_s) begin
                        r_timer <= '0;
                    end else if (r_timer == DEB_LAST) begin
                        r_state <= HOLDOFF;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (r_timer == HOLD_LAST) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Clear wins over a coincident visit; the visit is still consumed by the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_wE    <= 1'b0;
            r_sat   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_wE    <= 1'b1;
            r_sat   <= 1'b0;
        end else if (w_count_evt && (r_count != COUNT_MAX)) begin
            r_count <= r_count + 1'b1;
            r_wE    <= 1'b1;
            r_sat   <= (r_count == (COUNT_MAX - 1'b1));
        end else begin
            r_wE    <= 1'b0;
        end
    end

    assign count_out = r_count;
    assign count_wE  = r_wE;
    assign sat       = r_sat;

endmodule

// File: tb/tb_visit_counter_6bit.sv
// Directed bench for visit_counter_6bit with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
module tb_visit_counter_6bit;
    import visit_counter_6bit_pkg::*;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       beam_in = 1'b0;
    logic       clr     = 1'b0;
    logic [5:0] count_out;
    logic       count_wE;
    logic       sat;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    int p0;

    visit_counter_6bit #(
        .DEBOUNCE_CYCLES (4),
        .HOLDOFF_CYCLES  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .beam_in   (beam_in),
        .clr       (clr),
        .count_out (count_out),
        .count_wE  (count_wE),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (count_wE === 1'b1) n_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean visit: broken 8 edges, clear 16 edges; ends back in IDLE.
    task automatic visit();
        beam_in = 1'b1;
        tick(8);
        beam_in = 1'b0;
        tick(16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_count", count_out, 0);
        check("rst_we", count_wE, 0);
        check("rst_sat", sat, 0);
        check("rst_state", dut.r_state, IDLE);

        // 1: latency of the first count
        reset   = 1'b0;
        beam_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("t1_we_e%0d", k), count_wE, (k == 5));
            if (k == 5) check("t1_count_e5", count_out, 1);
        end
        beam_in = 1'b0;
        tick(20);
        check("t1_pulses", n_pulses, 1);
        check("t1_count", count_out, 1);

        // 2: short glitch rejected
        reset = 1'b1;
        tick();
        reset = 1'b0;
        p0 = n_pulses;
        beam_in = 1'b1;
        tick(3);
        beam_in = 1'b0;
        tick(10);
        check("t2_count", count_out, 0);
        check("t2_pulses", n_pulses - p0, 0);
        check("t2_state", dut.r_state, IDLE);

        // 3: two full visits, then a re-break inside holdoff
        p0 = n_pulses;
        beam_in = 1'b1; tick(10);
        beam_in = 1'b0; tick(20);
        beam_in = 1'b1; tick(10);
        check("t3_pulses", n_pulses - p0, 2);
        check("t3_count", count_out, 2);
        beam_in = 1'b0;
        tick(6);
        beam_in = 1'b1;
        for (int k = 6; k <= 20; k++) begin
            tick();
            check($sformatf("t3_holdoff_we_e%0d", k), count_wE, (k == 17));
        end
        check("t3_holdoff_count", count_out, 3);
        beam_in = 1'b0;
        tick(20);

        // 4: saturation and clear
        reset = 1'b1;
        tick();
        reset = 1'b0;
        p0 = n_pulses;
        repeat (62) visit();
        check("t4_count62", count_out, 62);
        check("t4_sat62", sat, 0);
        visit();
        check("t4_count63", count_out, 63);
        check("t4_sat63", sat, 1);
        check("t4_pulses63", n_pulses - p0, 63);
        visit();
        check("t4_count64", count_out, 63);
        check("t4_sat64", sat, 1);
        check("t4_pulses64", n_pulses - p0, 63);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_we", count_wE, 1);
        check("t4_clr_count", count_out, 0);
        check("t4_clr_sat", sat, 0);
        tick();
        check("t4_clr_we_off", count_wE, 0);

        // 5: clear coincident with a confirmed visit
        visit();
        check("t5_pre_count", count_out, 1);
        p0 = n_pulses;
        beam_in = 1'b1;
        tick(5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_we", count_wE, 1);
        check("t5_count", count_out, 0);
        tick(3);
        check("t5_we_off", count_wE, 0);
        check("t5_count_hold", count_out, 0);
        check("t5_pulses", n_pulses - p0, 1);
        check("t5_state", dut.r_state, OCCUPIED);
        beam_in = 1'b0;
        tick(20);

        // 6: reset mid-CONFIRM, then mid-OCCUPIED
        visit();
        check("t6_pre_count", count_out, 1);
        beam_in = 1'b1;
        tick(3);
        check("t6_in_confirm", dut.r_state, CONFIRM);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6a_count", count_out, 0);
        check("t6a_we", count_wE, 0);
        check("t6a_sat", sat, 0);
        check("t6a_state", dut.r_state, IDLE);
        for (int k = 4; k <= 11; k++) begin
            tick();
            check($sformatf("t6a_we_e%0d", k), count_wE, (k == 9));
        end
        check("t6a_count_after", count_out, 1);
        check("t6_in_occupied", dut.r_state, OCCUPIED);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6b_count", count_out, 0);
        check("t6b_we", count_wE, 0);
        check("t6b_state", dut.r_state, IDLE);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t6b_we_r%0d", k), count_wE, (k == 6));
        end
        check("t6b_count_after", count_out, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
